ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 114 +++++++++++
 tb/tb_ex_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage with a one-cycle ALU, registered branch resolution and store data.
// Define EX_MUL_EN to add the 33-cycle shift-add multiplier (op 10) and its stall FSM.
module ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] EX_a,
   input  logic [XLEN-1:0] EX_b,
   input  logic [XLEN-1:0] EX_a2,
   input  logic [XLEN-1:0] EX_b2,
   input  logic [3:0]      EX_alu_op,
   input  logic            EX_brn,
   input  logic            EX_ld,
   input  logic            EX_str,
   input  logic            EX_we,
   input  logic [4:0]      EX_rd,
   input  logic            flush,
   output logic            stall_EX,
   output logic [XLEN-1:0] MEM_res,
   output logic [XLEN-1:0] MEM_sd,
   output logic [4:0]      MEM_rd,
   output logic            MEM_ld,
   output logic            MEM_str,
   output logic            MEM_we,
   output logic            br_taken,
   output logic [XLEN-1:0] br_target
);
   logic [XLEN-1:0] alu;
   logic [XLEN-1:0] res;
   always_comb begin
      alu = '0;
      case (EX_alu_op)
         4'd0:    alu = EX_a + EX_b;
         4'd1:    alu = EX_a - EX_b;
         4'd2:    alu = EX_a & EX_b;
         4'd3:    alu = EX_a | EX_b;
         4'd4:    alu = EX_a ^ EX_b;
         4'd5:    alu = EX_a << EX_b[4:0];
         4'd6:    alu = EX_a >> EX_b[4:0];
         4'd7:    alu = $unsigned($signed(EX_a) >>> EX_b[4:0]);
         4'd8:    alu = {{(XLEN-1){1'b0}}, $signed(EX_a) < $signed(EX_b)};
         4'd9:    alu = {{(XLEN-1){1'b0}}, EX_a < EX_b};
         default: alu = '0;
      endcase
   end
`ifdef EX_MUL_EN
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0]      state;
   logic [4:0]      cnt;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic            is_mul;
   assign is_mul   = EX_alu_op == 4'd10;
   assign stall_EX = rst && !flush && ((state == IDLE && is_mul) || state == BUSY);
   assign res      = (state == DONE) ? acc : alu;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (state == IDLE && is_mul) begin
         mcand  <= EX_a;
         mplier <= EX_b;
         acc    <= '0;
         cnt    <= '0;
         state  <= BUSY;
      end else if (state == BUSY) begin
         // one partial product per cycle, low XLEN bits only
         acc    <= acc + (mplier[0] ? mcand : '0);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 5'd1;
         state  <= (cnt == 5'd31) ? DONE : BUSY;
      end else if (state == DONE) begin
         state <= IDLE;
      end
`else
   assign stall_EX = 1'b0;
   assign res      = alu;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         MEM_res   <= '0;
         MEM_sd    <= '0;
         MEM_rd    <= '0;
         MEM_ld    <= 1'b0;
         MEM_str   <= 1'b0;
         MEM_we    <= 1'b0;
         br_taken  <= 1'b0;
         br_target <= '0;
      end else if (flush || stall_EX) begin
         MEM_ld   <= 1'b0;
         MEM_str  <= 1'b0;
         MEM_we   <= 1'b0;
         br_taken <= 1'b0;
      end else begin
         MEM_res  <= res;
         MEM_sd   <= EX_b2;
         MEM_rd   <= EX_rd;
         MEM_ld   <= EX_ld;
         MEM_str  <= EX_str;
         MEM_we   <= EX_we;
         br_taken <= EX_brn && (EX_a2 == EX_b2);
         if (EX_brn)
            br_target <= EX_a + EX_b;
      end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; register writes are matched against a queue of
// expected results, branch/store/stall/flush/reset behaviour is checked inline.
module tb_ex_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] EX_a, EX_b, EX_a2, EX_b2;
   logic [3:0]  EX_alu_op;
   logic        EX_brn, EX_ld, EX_str, EX_we;
   logic [4:0]  EX_rd;
   logic        flush;
   logic        stall_EX;
   logic [31:0] MEM_res, MEM_sd, br_target;
   logic [4:0]  MEM_rd;
   logic        MEM_ld, MEM_str, MEM_we, br_taken;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .EX_a(EX_a), .EX_b(EX_b), .EX_a2(EX_a2), .EX_b2(EX_b2),
      .EX_alu_op(EX_alu_op), .EX_brn(EX_brn), .EX_ld(EX_ld), .EX_str(EX_str), .EX_we(EX_we),
      .EX_rd(EX_rd), .flush(flush), .stall_EX(stall_EX), .MEM_res(MEM_res), .MEM_sd(MEM_sd),
      .MEM_rd(MEM_rd), .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_we(MEM_we),
      .br_taken(br_taken), .br_target(br_target)
   );

`ifdef EX_MUL_EN
   localparam int          MUL_ST = 33;
   localparam logic [31:0] MUL_FF = 32'd1;
   localparam logic [31:0] MUL_A  = 32'd97406784;
`else
   localparam int          MUL_ST = 0;
   localparam logic [31:0] MUL_FF = 32'd0;
   localparam logic [31:0] MUL_A  = 32'd0;
`endif

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (rst === 1'b1 && MEM_we === 1'b1) begin
         if (sb.size() == 0)
            check("spurious_we", 32'(MEM_we), 32'd0);
         else begin
            mon_e = sb.pop_front();
            check("res", MEM_res, mon_e.res);
            check("rd", 32'(MEM_rd), 32'(mon_e.rd));
         end
      end

   task automatic idle_inputs;
      EX_a = '0; EX_b = '0; EX_a2 = '0; EX_b2 = '0; EX_alu_op = '0;
      EX_brn = 1'b0; EX_ld = 1'b0; EX_str = 1'b0; EX_we = 1'b0; EX_rd = '0; flush = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic we, input logic [31:0] exp,
                        input logic brn, input logic [31:0] a2, input logic [31:0] b2,
                        input logic str, input logic scr, output int stalls);
      @(negedge clk); #1;
      EX_alu_op = op; EX_a = a; EX_b = b; EX_rd = rd; EX_we = we;
      EX_brn = brn; EX_a2 = a2; EX_b2 = b2; EX_str = str;
      if (we) sb.push_back('{res: exp, rd: rd});
      stalls = 0;
      #1;
      while (stall_EX && stalls < 100) begin
         stalls++;
         check("bubble_we", 32'(MEM_we), 32'd0);
         check("bubble_br", 32'(br_taken), 32'd0);
         if (scr && stalls == 5) begin
            EX_a = $urandom;
            EX_b = $urandom;
         end
         @(negedge clk); #2;
      end
      check("stall_bound", 32'(stalls >= 100), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk); #1;
      if (we) check("drain", sb.size(), 32'd0);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, exp;
      logic [4:0]  rd;
   } vec_t;
   vec_t vec[11] = '{
      '{4'd0,  32'hFFFFFFFF, 32'd2,         32'd1,         5'd5},
      '{4'd1,  32'd3,        32'd5,         32'hFFFFFFFE,  5'd6},
      '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00,  32'hF000F000,  5'd7},
      '{4'd3,  32'hF0F0F0F0, 32'h0F0F0000,  32'hFFFFF0F0,  5'd8},
      '{4'd4,  32'hFFFF0000, 32'hFF00FF00,  32'h00FFFF00,  5'd9},
      '{4'd5,  32'd1,        32'h23,        32'd8,         5'd10},
      '{4'd6,  32'h80000000, 32'd4,         32'h08000000,  5'd11},
      '{4'd7,  32'h80000000, 32'd4,         32'hF8000000,  5'd12},
      '{4'd8,  32'hFFFFFFFF, 32'd1,         32'd1,         5'd13},
      '{4'd9,  32'hFFFFFFFF, 32'd1,         32'd0,         5'd14},
      '{4'd13, 32'd1,        32'd1,         32'd0,         5'd15}
   };

   initial begin
      #100000;
      $display("FAIL watchdog time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      logic [31:0] ra, rb;
      idle_inputs();
      EX_alu_op = 4'd10;
      rst = 1'b0;
      #7;
      check("rst_stall", 32'(stall_EX), 32'd0);
      check("rst_res", MEM_res, 32'd0);
      check("rst_we", 32'(MEM_we), 32'd0);
      check("rst_br", 32'(br_taken), 32'd0);
      idle_inputs();
      @(negedge clk); rst = 1'b1;
      foreach (vec[i]) begin
         issue(vec[i].op, vec[i].a, vec[i].b, vec[i].rd, 1'b1, vec[i].exp, 1'b0, '0, '0, 1'b0, 1'b0, st);
         check("alu_stall", st, 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         ra = $urandom; rb = $urandom;
         issue(i[0] ? 4'd1 : 4'd0, ra, rb, 5'(i + 20), 1'b1, i[0] ? ra - rb : ra + rb, 1'b0, '0, '0, 1'b0, 1'b0, st);
      end
      issue(4'd0, 32'h100, 32'h20, 5'd0, 1'b0, '0, 1'b1, 32'd7, 32'd7, 1'b0, 1'b0, st);
      check("br_taken", 32'(br_taken), 32'd1);
      check("br_target", br_target, 32'h120);
      @(negedge clk); #1;
      check("br_pulse", 32'(br_taken), 32'd0);
      issue(4'd0, 32'h100, 32'h20, 5'd0, 1'b0, '0, 1'b1, 32'd7, 32'd8, 1'b0, 1'b0, st);
      check("br_not_taken", 32'(br_taken), 32'd0);
      issue(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, '0, 1'b0, '0, 32'hDEAD, 1'b1, 1'b0, st);
      check("str", 32'(MEM_str), 32'd1);
      check("sd", MEM_sd, 32'hDEAD);
      issue(4'd10, 32'd123456, 32'd789, 5'd3, 1'b1, MUL_A, 1'b1, 32'd3, 32'd3, 1'b0, 1'b0, st);
      check("mul_stall", st, MUL_ST);
      check("mul_br", 32'(br_taken), 32'd1);
      check("mul_br_target", br_target, 32'd124245);
      @(negedge clk); #1;
      check("mul_we_pulse", 32'(MEM_we), 32'd0);
      @(negedge clk); #1;
      EX_alu_op = 4'd0; EX_a = 32'd1; EX_b = 32'd1; EX_we = 1'b1; EX_rd = 5'd7;
      EX_brn = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk); #1;
      check("flush_we", 32'(MEM_we), 32'd0);
      check("flush_br", 32'(br_taken), 32'd0);
`ifdef EX_MUL_EN
      @(negedge clk); #1;
      EX_alu_op = 4'd10; EX_a = 32'd5; EX_b = 32'd6; EX_we = 1'b1; EX_rd = 5'd9;
      repeat (10) @(negedge clk);
      #1;
      check("busy_stall", 32'(stall_EX), 32'd1);
      flush = 1'b1;
      #1;
      check("flush_stall", 32'(stall_EX), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
`endif
      issue(4'd0, 32'd2, 32'd3, 5'd4, 1'b1, 32'd5, 1'b0, '0, '0, 1'b0, 1'b0, st);
      check("post_flush_stall", st, 32'd0);
      @(negedge clk); #1;
      EX_alu_op = 4'd10; EX_a = 32'd7; EX_b = 32'd9; EX_we = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_res", MEM_res, 32'd0);
      check("arst_rd", 32'(MEM_rd), 32'd0);
      check("arst_target", br_target, 32'd0);
      check("arst_stall", 32'(stall_EX), 32'd0);
      idle_inputs();
      @(negedge clk); rst = 1'b1;
      issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1, MUL_FF, 1'b0, '0, '0, 1'b0, 1'b1, st);
      check("mul_ff_stall", st, MUL_ST);
      repeat (2) @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
